// File: rtl/glitch_pulse_gen_pkg.sv
// Shared encodings and config field widths for the glitch pulse generator.
package glitch_pkg;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int COUNT_W   = 8;
    localparam int SPACING_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_SPACE = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DELAY = ST_DELAY,
        PULSE = ST_PULSE,
        SPACE = ST_SPACE
    } state_t;

endpackage

// File: rtl/glitch_pulse_gen_if.sv
// Config/trigger inputs and status outputs of the glitch pulse generator.
interface glitch_pulse_gen_if;
    import glitch_pkg::*;

    // No valid/ready: config is sampled only on an accepted trigger rise; done_o is a one-cycle strobe.
    logic                 trigger_i;
    logic                 pulse_en;
    logic [DELAY_W-1:0]   delay_i;
    logic [WIDTH_W-1:0]   width_i;
    logic [COUNT_W-1:0]   num_pulses_i;
    logic [SPACING_W-1:0] pulse_spacing_i;
    logic                 glitch_o;
    logic                 busy_o;
    logic                 done_o;

    modport master (
        output trigger_i, pulse_en, delay_i, width_i, num_pulses_i, pulse_spacing_i,
        input  glitch_o, busy_o, done_o
    );

    modport slave (
        input  trigger_i, pulse_en, delay_i, width_i, num_pulses_i, pulse_spacing_i,
        output glitch_o, busy_o, done_o
    );

endinterface

// File: rtl/glitch_pulse_gen_sync_rise_detect.sv
// Multi-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Trigger-armed glitch pulse train generator: delay, then num pulses of width with spacing gaps.
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    glitch_pulse_gen_if.slave        bus,
    output state_t                   state
);

    logic rise;

    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.trigger_i),
        .rise_o  (rise)
    );

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [COUNT_W-1:0]   left_q, left_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [SPACING_W-1:0] spacing_q, spacing_d;
    logic                 glitch_q, glitch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            left_q    <= '0;
            delay_q   <= '0;
            width_q   <= '0;
            spacing_q <= '0;
            glitch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            delay_q   <= delay_d;
            width_q   <= width_d;
            spacing_q <= spacing_d;
            glitch_q  <= glitch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // cnt counts cycles already spent in the current phase, including the entry cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        delay_d   = delay_q;
        width_d   = width_q;
        spacing_d = spacing_q;
        glitch_d  = glitch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise && bus.pulse_en) begin
                    delay_d   = bus.delay_i;
                    width_d   = bus.width_i;
                    left_d    = bus.num_pulses_i;
                    spacing_d = bus.pulse_spacing_i;
                    if (bus.width_i == '0 || bus.num_pulses_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        cnt_d  = 16'd1;
                        if (bus.delay_i == '0) begin
                            state_d  = PULSE;
                            glitch_d = 1'b1;
                        end else begin
                            state_d = DELAY;
                        end
                    end
                end
            end
            DELAY: begin
                if (cnt_q == delay_q) begin
                    state_d  = PULSE;
                    glitch_d = 1'b1;
                    cnt_d    = 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PULSE: begin
                if (cnt_q == {8'd0, width_q}) begin
                    cnt_d  = 16'd1;
                    left_d = left_q - 8'd1;
                    if (left_q == 8'd1) begin
                        state_d  = IDLE;
                        glitch_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                    end else if (spacing_q != '0) begin
                        state_d  = SPACE;
                        glitch_d = 1'b0;
                    end else begin
                        glitch_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SPACE: begin
                if (cnt_q == spacing_q) begin
                    state_d  = PULSE;
                    glitch_d = 1'b1;
                    cnt_d    = 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disarming mid-sequence aborts silently, without a done strobe.
        if (state_q != IDLE && !bus.pulse_en) begin
            state_d  = IDLE;
            glitch_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
            left_d   = '0;
        end
    end

    assign bus.glitch_o = glitch_q;
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign state        = state_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Bench for glitch_pulse_gen: table vectors plus abort, retrigger and reset sequences.
module tb_glitch_pulse_gen;
    import glitch_pkg::*;

    typedef struct {
        logic [15:0] delay;
        logic [7:0]  width;
        logic [7:0]  num;
        logic [15:0] spacing;
        int          exp_len;
        int          exp_high;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t state;

    glitch_pulse_gen_if bus ();

    glitch_pulse_gen #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (state)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [2:0] exp_q[$];
    vec_t       vecs[8];

    task automatic check_obs(input string name, input int k, input logic [2:0] got, input logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: glitch/busy/done got %b required %b", name, k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic int seq_len(input vec_t c);
        if (c.width == 0 || c.num == 0) return 0;
        return int'(c.delay) + int'(c.num) * int'(c.width) + (int'(c.num) - 1) * int'(c.spacing);
    endfunction

    // Expected {glitch,busy,done} after edge E(k); the FSM accepts the trigger at E2.
    function automatic logic [2:0] exp_at(input vec_t c, input int len, input int k, input int cut);
        int j, p, per;
        j = k - 2;
        if (j < 0) return 3'b000;
        if (cut >= 0 && j > cut) return 3'b000;
        if (c.width == 0 || c.num == 0) return (j == 0) ? 3'b001 : 3'b000;
        if (j == len) return 3'b001;
        if (j > len) return 3'b000;
        if (j < int'(c.delay)) return 3'b010;
        p   = j - int'(c.delay);
        per = int'(c.width) + int'(c.spacing);
        return ((p % per) < int'(c.width)) ? 3'b110 : 3'b010;
    endfunction

    task automatic run_seq(input string name, input vec_t c, input int len, input int cut,
                           input bit use_rst, input bit retrig, output int highs);
        int         n;
        logic [2:0] got;
        @(posedge clk);
        #1;
        bus.delay_i         = c.delay;
        bus.width_i         = c.width;
        bus.num_pulses_i    = c.num;
        bus.pulse_spacing_i = c.spacing;
        bus.pulse_en        = 1'b1;
        bus.trigger_i       = 1'b1;
        n = (cut >= 0) ? cut + 8 : len + 6;
        for (int k = 0; k < n; k++) exp_q.push_back(exp_at(c, len, k, cut));
        highs = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                bus.delay_i         = 16'($urandom_range(0, 65535));
                bus.width_i         = 8'($urandom_range(0, 255));
                bus.num_pulses_i    = 8'($urandom_range(0, 255));
                bus.pulse_spacing_i = 16'($urandom_range(0, 65535));
            end
            if (retrig && k == 3) bus.trigger_i = 1'b0;
            if (retrig && k == 6) bus.trigger_i = 1'b1;
            if (cut >= 0 && k == cut + 2) begin
                bus.trigger_i = 1'b0;
                if (use_rst) rst_n = 1'b0;
                else bus.pulse_en = 1'b0;
            end
            if (use_rst && k == cut + 3) rst_n = 1'b1;
            @(negedge clk);
            got = {bus.glitch_o, bus.busy_o, bus.done_o};
            check_obs(name, k, got, exp_q.pop_front());
            if (got[2]) highs++;
        end
        bus.trigger_i = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        vec_t c;
        int   highs;
        logic [2:0] got;

        vecs[0] = '{delay: 16'd3,   width: 8'd2,   num: 8'd1,   spacing: 16'd0,   exp_len: 5,   exp_high: 2};
        vecs[1] = '{delay: 16'd0,   width: 8'd1,   num: 8'd3,   spacing: 16'd2,   exp_len: 7,   exp_high: 3};
        vecs[2] = '{delay: 16'd0,   width: 8'd4,   num: 8'd2,   spacing: 16'd0,   exp_len: 8,   exp_high: 8};
        vecs[3] = '{delay: 16'd5,   width: 8'd0,   num: 8'd3,   spacing: 16'd1,   exp_len: 0,   exp_high: 0};
        vecs[4] = '{delay: 16'd2,   width: 8'd3,   num: 8'd0,   spacing: 16'd4,   exp_len: 0,   exp_high: 0};
        vecs[5] = '{delay: 16'd300, width: 8'd255, num: 8'd1,   spacing: 16'd0,   exp_len: 555, exp_high: 255};
        vecs[6] = '{delay: 16'd1,   width: 8'd3,   num: 8'd2,   spacing: 16'd260, exp_len: 267, exp_high: 6};
        vecs[7] = '{delay: 16'd7,   width: 8'd1,   num: 8'd255, spacing: 16'd0,   exp_len: 262, exp_high: 255};

        bus.trigger_i       = 1'b0;
        bus.pulse_en        = 1'b0;
        bus.delay_i         = '0;
        bus.width_i         = '0;
        bus.num_pulses_i    = '0;
        bus.pulse_spacing_i = '0;
        rst_n               = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_obs("reset_outputs", 0, {bus.glitch_o, bus.busy_o, bus.done_o}, 3'b000);
        check_int("reset_state", int'(state), int'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_seq($sformatf("vec%0d", i), vecs[i], vecs[i].exp_len, -1, 1'b0, 1'b0, highs);
            check_int($sformatf("vec%0d_high_cycles", i), highs, vecs[i].exp_high);
        end

        for (int i = 0; i < 3; i++) begin
            c.delay   = 16'($urandom_range(0, 20));
            c.width   = 8'($urandom_range(1, 6));
            c.num     = 8'($urandom_range(1, 5));
            c.spacing = 16'($urandom_range(0, 6));
            run_seq($sformatf("rand%0d", i), c, seq_len(c), -1, 1'b0, 1'b0, highs);
            check_int($sformatf("rand%0d_high_cycles", i), highs, int'(c.num) * int'(c.width));
        end

        c = '{delay: 16'd10, width: 8'd2, num: 8'd2, spacing: 16'd3, exp_len: 0, exp_high: 0};
        run_seq("retrig_in_delay", c, seq_len(c), -1, 1'b0, 1'b1, highs);
        check_int("retrig_high_cycles", highs, 4);

        // Disarm during the second pulse (j=22), then retrigger while disarmed.
        c = '{delay: 16'd10, width: 8'd5, num: 8'd4, spacing: 16'd5, exp_len: 0, exp_high: 0};
        run_seq("abort", c, seq_len(c), 22, 1'b0, 1'b0, highs);
        check_int("abort_high_cycles", highs, 8);
        for (int k = 0; k < 14; k++) exp_q.push_back(3'b000);
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) bus.trigger_i = 1'b1;
            if (k == 10) bus.pulse_en = 1'b1;
            @(negedge clk);
            got = {bus.glitch_o, bus.busy_o, bus.done_o};
            check_obs("retrig_while_disarmed", k, got, exp_q.pop_front());
        end
        bus.trigger_i = 1'b0;
        repeat (4) @(posedge clk);

        c = '{delay: 16'd0, width: 8'd10, num: 8'd1, spacing: 16'd0, exp_len: 0, exp_high: 0};
        run_seq("reset_mid_pulse", c, seq_len(c), 4, 1'b1, 1'b0, highs);
        check_int("reset_mid_high_cycles", highs, 5);
        check_int("reset_mid_state", int'(state), int'(IDLE));

        c = '{delay: 16'd2, width: 8'd2, num: 8'd2, spacing: 16'd1, exp_len: 0, exp_high: 0};
        run_seq("after_reset", c, seq_len(c), -1, 1'b0, 1'b0, highs);
        check_int("after_reset_high_cycles", highs, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/glitch_pulse_gen.md
Name: glitch_pulse_gen

Overview:
- Downstream consumer of the UART command handler's configuration outputs (delay, width, pulse count, spacing, enable).
- On a rising edge of an external trigger, waits a programmable delay, then emits a train of glitch pulses of programmable width, count and spacing on glitch_o.
- Drives the glitch output stage directly and reports busy/done status back to the control logic.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the trigger synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- trigger_i  in  1  asynchronous external trigger; the sequence starts on its rising edge.
- pulse_en  in  1  arm level; triggers are ignored while low.
- delay_i  in  16  clk cycles from trigger detection to the first pulse.
- width_i  in  8  high cycles per pulse.
- num_pulses_i  in  8  pulses per sequence.
- pulse_spacing_i  in  16  low cycles between consecutive pulses.
- glitch_o  out  1  registered glitch pulse output.
- busy_o  out  1  high while a sequence is running.
- done_o  out  1  one-cycle strobe when a sequence completes normally.

Behaviour:
- Reset (rst_n low at a clk edge): glitch_o=0, busy_o=0, done_o=0, state=IDLE, all counters 0, synchroniser flops 0, edge-detect history 0. Reset mid-sequence kills the pulse on that edge.
- Synchroniser: trigger_i passes through a SYNC_STAGES flop chain. rise = sync_out & ~sync_prev.
- States: IDLE, DELAY, PULSE, SPACE.
- IDLE:
  - When rise && pulse_en, latch all four config inputs into shadow registers and set busy_o=1.
  - Config input changes during a sequence have no effect.
  - Next state: DELAY if delay>0; PULSE if delay==0.
  - If width==0 or num_pulses==0: do not leave IDLE; pulse done_o for one cycle; busy_o stays 0; glitch_o never asserts.
- Timing: let E0 be the first clk edge sampling trigger_i high.
  - The FSM leaves IDLE at edge E(SYNC_STAGES).
  - glitch_o rises at edge E(SYNC_STAGES+delay).
- DELAY: count delay cycles, then enter PULSE with glitch_o=1.
- PULSE: glitch_o high for exactly width cycles. At its end, decrement the remaining pulse count.
  - If pulses remain and spacing>0: go to SPACE with glitch_o=0.
  - If pulses remain and spacing==0: start the next pulse directly, so glitch_o stays high continuously (num_pulses×width cycles total).
  - If this was the last pulse: glitch_o=0, busy_o=0, done_o=1 on the same edge, return to IDLE.
- SPACE: glitch_o low for exactly spacing cycles, then PULSE.
- Abort: pulse_en sampled low in any non-IDLE state means that edge sets glitch_o=0, busy_o=0, state=IDLE, no done_o.
- Retrigger: rise events while busy_o=1 are ignored (not queued).
- Re-arm: a new trigger is accepted the cycle after the sequence returns to IDLE; the trigger must go low and then high again.
- Widths: counters match their config widths. delay=65535 and spacing=65535 must not wrap early. width=255 and num_pulses=255 are exact.
- done_o is high for exactly one cycle per completed sequence.

Decomposition:
- Package glitch_pkg holds:
  - state encoding localparams (2-bit IDLE/DELAY/PULSE/SPACE);
  - config field widths: DELAY_W=16, WIDTH_W=8, COUNT_W=8, SPACING_W=16.
- Sub-module sync_rise_detect (parameter SYNC_STAGES; ports clk, rst_n, async_i, rise_o) holds the synchroniser plus edge detect, for reuse by other trigger inputs.

Test Plan:
- delay=3, width=2, num=1, spacing=0, en=1, trigger rises before E0 -> glitch_o high edges E5–E6 (2 cycles), then done_o=1 at E7 with busy_o falling.
- delay=0, width=1, num=3, spacing=2 -> glitch_o pattern 1,0,0,1,0,0,1 starting at E2; done_o once after the third pulse.
- delay=0, width=4, num=2, spacing=0 -> glitch_o high for 8 contiguous cycles; one done_o.
- width=0 or num=0, trigger -> glitch_o stays 0, busy_o stays 0, single done_o strobe.
- delay=10, width=5, num=4, spacing=5; drop pulse_en during the second pulse -> glitch_o low next edge, busy_o=0, no done_o; a retrigger 3 cycles later while en=0 is ignored.
- A second trigger edge during the DELAY of an active sequence -> ignored, exactly num pulses emitted. rst_n low mid-PULSE -> all outputs 0 on that edge.
